// File: rtl/serializer_driver_pkg.sv
// Shared types and constants for the serializer driver and its byte FIFO.
package serializer_driver_pkg;

   localparam int BITS_PER_WORD = 8;
   localparam int BIT_IDX_W     = $clog2(BITS_PER_WORD);
   // Wide enough for any legal DIV (1..255).
   localparam int PHASE_W       = 8;

   localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(BITS_PER_WORD - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      FLUSH
   } state_e;

endpackage

// File: rtl/serializer_driver_fifo.sv
// Byte FIFO between the packer handshake and the serializer driver FSM.
module byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic [7:0] wdata_i,
   output logic [7:0] rdata_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int ADDR_W = $clog2(DEPTH);

   logic [7:0]      mem [DEPTH];
   logic [ADDR_W:0] wrPtr_q;
   logic [ADDR_W:0] rdPtr_q;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         if (push_i) wrPtr_q <= wrPtr_q + (ADDR_W + 1)'(1);
         if (pop_i)  rdPtr_q <= rdPtr_q + (ADDR_W + 1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem[wrPtr_q[ADDR_W-1:0]] <= wdata_i;
   end

   assign rdata_o = mem[rdPtr_q[ADDR_W-1:0]];
   assign empty_o = (wrPtr_q == rdPtr_q);
   assign full_o  = (wrPtr_q[ADDR_W] != rdPtr_q[ADDR_W]) &&
                    (wrPtr_q[ADDR_W-1:0] == rdPtr_q[ADDR_W-1:0]);

endmodule

// File: rtl/serializer_driver.sv
// Drives an 8-bit PISO serializer: buffers bytes, generates clk_ser, clk_par and data_par MSB-first.
// Define SERIALIZER_DRIVER_IDLE_CLK_EN to keep clk_ser toggling while IDLE.
module serializer_driver
   import serializer_driver_pkg::*;
#(
   parameter int DIV        = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        clk_ser,
   output logic        clk_par,
   output logic [7:0]  data_par,
   output logic        busy,
   output logic [15:0] bytes_sent
);

   state_e               state_q;
   logic [PHASE_W-1:0]   phase_q;
   logic [PHASE_W-1:0]   phase_d;
   logic [BIT_IDX_W-1:0] bitIdx_q;
   logic                 clkSer_q;
   logic                 clkPar_q;
   logic [7:0]           dataPar_q;
   logic [15:0]          bytesSent_q;

   logic                 phaseWrap;
   logic                 pushEn;
   logic                 popEn;
   logic                 fifoFull;
   logic                 fifoEmpty;
   logic [7:0]           fifoHead;

   assign in_ready = ~fifoFull;
   assign pushEn   = in_valid & ~fifoFull;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .push_i    (pushEn),
      .pop_i     (popEn),
      .wdata_i   (in_data),
      .rdata_o   (fifoHead),
      .full_o    (fifoFull),
      .empty_o   (fifoEmpty)
   );

   assign phaseWrap = (phase_q == PHASE_W'(DIV - 1));
   assign phase_d   = phaseWrap ? '0 : phase_q + PHASE_W'(1);

   // A new byte may only start on a rising clk_ser edge (or straight away from a stopped IDLE).
   always_comb begin
      popEn = 1'b0;
      if (!fifoEmpty) begin
         case (state_q)
`ifdef SERIALIZER_DRIVER_IDLE_CLK_EN
            IDLE:    popEn = phaseWrap && !clkSer_q;
`else
            IDLE:    popEn = 1'b1;
`endif
            SHIFT:   popEn = phaseWrap && !clkSer_q && (bitIdx_q == LAST_BIT);
            FLUSH:   popEn = phaseWrap && !clkSer_q;
            default: popEn = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         phase_q     <= '0;
         bitIdx_q    <= '0;
         clkSer_q    <= 1'b0;
         clkPar_q    <= 1'b1;
         dataPar_q   <= '0;
         bytesSent_q <= '0;
      end else begin
         phase_q <= phase_d;
         if (popEn) begin
            dataPar_q <= fifoHead;
            clkPar_q  <= 1'b0;
            clkSer_q  <= 1'b1;
            bitIdx_q  <= '0;
            phase_q   <= '0;
            state_q   <= LOAD;
         end else begin
            case (state_q)
               IDLE: begin
`ifdef SERIALIZER_DRIVER_IDLE_CLK_EN
                  if (phaseWrap) clkSer_q <= ~clkSer_q;
`else
                  phase_q  <= '0;
                  clkSer_q <= 1'b0;
`endif
               end
               LOAD: begin
                  if (phaseWrap) begin
                     clkSer_q <= ~clkSer_q;
                     if (!clkSer_q) begin
                        clkPar_q <= 1'b1;
                        bitIdx_q <= BIT_IDX_W'(1);
                        state_q  <= SHIFT;
                     end
                  end
               end
               SHIFT: begin
                  if (phaseWrap) begin
                     clkSer_q <= ~clkSer_q;
                     // The falling edge inside bit 7 is where the serializer takes the last bit.
                     if (clkSer_q) begin
                        if (bitIdx_q == LAST_BIT) bytesSent_q <= bytesSent_q + 16'd1;
                     end else if (bitIdx_q == LAST_BIT) begin
                        state_q <= FLUSH;
                     end else begin
                        bitIdx_q <= bitIdx_q + BIT_IDX_W'(1);
                     end
                  end
               end
               FLUSH: begin
                  if (phaseWrap) begin
                     clkSer_q <= ~clkSer_q;
                     if (!clkSer_q) begin
                        state_q <= IDLE;
`ifndef SERIALIZER_DRIVER_IDLE_CLK_EN
                        clkSer_q <= 1'b0;
`endif
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign clk_ser    = clkSer_q;
   assign clk_par    = clkPar_q;
   assign data_par   = dataPar_q;
   assign busy       = (state_q != IDLE);
   assign bytes_sent = bytesSent_q;

endmodule

// File: tb/tb_serializer_driver.sv
// Randomised self-checking bench for serializer_driver, scored against a behavioural PISO serializer model.
// Define SERIALIZER_DRIVER_IDLE_CLK_EN to also exercise the free-running idle clock.
module tb_serializer_driver;

   localparam int DIV   = 2;
   localparam int DEPTH = 4;

   logic        clk      = 1'b0;
   logic        reset_n  = 1'b0;
   logic [7:0]  in_data  = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        clk_ser;
   logic        clk_par;
   logic [7:0]  data_par;
   logic        busy;
   logic [15:0] bytes_sent;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [7:0] expQ[$];
   logic [7:0] rxBytes[$];
   logic       rxBits[$];
   int         parLowLens[$];
   int         loadCycles[$];

   logic       prevSer   = 1'b0;
   int         parLowRun = 0;
   int         bitCnt    = 0;
   logic [7:0] shReg     = '0;
   logic [7:0] acc       = '0;

   serializer_driver #(
      .DIV        (DIV),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .clk_ser    (clk_ser),
      .clk_par    (clk_par),
      .data_par   (data_par),
      .busy       (busy),
      .bytes_sent (bytes_sent)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural serializer: loads on a clk_ser fall with clk_par low, otherwise shifts MSB-first.
   always @(negedge clk) begin
      if (!reset_n) begin
         prevSer   = 1'b0;
         parLowRun = 0;
         bitCnt    = 0;
      end else begin
         if (prevSer && !clk_ser) begin
            if (!clk_par) begin
               shReg  = data_par;
               bitCnt = 0;
            end
            if (!clk_par || (bitCnt > 0 && bitCnt < 8)) begin
               rxBits.push_back(shReg[7]);
               acc   = {acc[6:0], shReg[7]};
               shReg = {shReg[6:0], 1'b0};
               bitCnt++;
               if (bitCnt == 8) begin
                  rxBytes.push_back(acc);
                  bitCnt = 0;
               end
            end
         end
         if (!clk_par) begin
            if (parLowRun == 0) loadCycles.push_back(cyc);
            parLowRun++;
         end else if (parLowRun != 0) begin
            parLowLens.push_back(parLowRun);
            parLowRun = 0;
         end
         prevSer = clk_ser;
      end
   end

   task automatic pushByte(input logic [7:0] b, output int acceptCyc);
      bit done;
      done      = 1'b0;
      acceptCyc = -1;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      for (int t = 0; t < 4000 && !done; t++) begin
         if (in_ready) begin
            acceptCyc = cyc + 1;
            @(posedge clk);
            expQ.push_back(b);
            done = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL push_timeout: in_ready stayed 0, byte %0h not accepted", b);
      end
   endtask

   task automatic waitDrain(input int n, output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 20000 && !ok; t++) begin
         @(negedge clk);
         ok = (rxBytes.size() >= n) && !busy;
      end
   endtask

   task automatic test_reset();
      bit toggled;
      reset_n  = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks += 6;
      if (clk_ser !== 1'b0)    begin errors++; $display("[TB] FAIL reset_clk_ser: got %b expected 0", clk_ser); end
      if (clk_par !== 1'b1)    begin errors++; $display("[TB] FAIL reset_clk_par: got %b expected 1", clk_par); end
      if (data_par !== 8'h00)  begin errors++; $display("[TB] FAIL reset_data_par: got %h expected 00", data_par); end
      if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      if (bytes_sent !== 16'd0) begin errors++; $display("[TB] FAIL reset_bytes_sent: got %0d expected 0", bytes_sent); end
      if (in_ready !== 1'b1)   begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
      reset_n = 1'b1;
      toggled = 1'b0;
      repeat (8 * DIV) begin
         @(negedge clk);
         if (clk_ser !== 1'b0 || clk_par !== 1'b1) toggled = 1'b1;
      end
`ifndef SERIALIZER_DRIVER_IDLE_CLK_EN
      checks++;
      if (toggled) begin errors++; $display("[TB] FAIL idle_quiet: got activity expected clk_ser=0 clk_par=1"); end
`endif
   endtask

   task automatic test_single_byte();
      logic [7:0] b;
      int  acceptCyc, busyCycles, rxBase, bitBase, lowBase, loadBase, lat;
      bit  seen;
      b        = 8'hA5;
      rxBase   = rxBytes.size();
      bitBase  = rxBits.size();
      lowBase  = parLowLens.size();
      loadBase = loadCycles.size();
      pushByte(b, acceptCyc);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
`ifndef SERIALIZER_DRIVER_IDLE_CLK_EN
      checks += 3;
      if (busy !== 1'b1)    begin errors++; $display("[TB] FAIL pop_busy: got %b expected 1", busy); end
      if (clk_par !== 1'b0) begin errors++; $display("[TB] FAIL pop_clk_par: got %b expected 0", clk_par); end
      if (clk_ser !== 1'b1) begin errors++; $display("[TB] FAIL pop_clk_ser: got %b expected 1", clk_ser); end
`endif
      busyCycles = 0;
      seen       = 1'b0;
      for (int t = 0; t < 2000; t++) begin
         if (busy) begin
            busyCycles++;
            seen = 1'b1;
         end else if (seen) begin
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (busyCycles != 18 * DIV) begin errors++; $display("[TB] FAIL single_busy_len: got %0d expected %0d", busyCycles, 18 * DIV); end
      checks += 2;
      if (rxBytes.size() != rxBase + 1) begin errors++; $display("[TB] FAIL single_count: got %0d expected %0d", rxBytes.size(), rxBase + 1); end
      if (rxBytes[rxBase] !== b) begin errors++; $display("[TB] FAIL single_byte: got %h expected %h", rxBytes[rxBase], b); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (rxBits[bitBase + i] !== b[7 - i]) begin
            errors++;
            $display("[TB] FAIL single_bit%0d: got %b expected %b", i, rxBits[bitBase + i], b[7 - i]);
         end
      end
      checks += 2;
      if (parLowLens[lowBase] != 2 * DIV) begin errors++; $display("[TB] FAIL single_par_low: got %0d expected %0d", parLowLens[lowBase], 2 * DIV); end
      if (bytes_sent !== 16'd1) begin errors++; $display("[TB] FAIL single_bytes_sent: got %0d expected 1", bytes_sent); end
      lat = loadCycles[loadBase] - acceptCyc;
      checks++;
`ifdef SERIALIZER_DRIVER_IDLE_CLK_EN
      if (lat < 1 || lat > 2 * DIV) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 1..%0d", lat, 2 * DIV); end
`else
      if (lat != 1) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 1", lat); end
`endif
   endtask

   task automatic test_back_to_back();
      logic [7:0] pat [4];
      int  acceptCyc, rxBase, lowBase, loadBase;
      logic [15:0] sentBase;
      bit  ok;
      pat      = '{8'h01, 8'h80, 8'hFF, 8'h00};
      rxBase   = rxBytes.size();
      lowBase  = parLowLens.size();
      loadBase = loadCycles.size();
      sentBase = bytes_sent;
      for (int i = 0; i < 4; i++) pushByte(pat[i], acceptCyc);
      @(negedge clk);
      in_valid = 1'b0;
      waitDrain(rxBase + 4, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL b2b_drain: got %0d bytes expected %0d", rxBytes.size() - rxBase, 4); end
      for (int i = 0; i < 4; i++) begin
         checks += 2;
         if (rxBytes[rxBase + i] !== pat[i]) begin errors++; $display("[TB] FAIL b2b_byte%0d: got %h expected %h", i, rxBytes[rxBase + i], pat[i]); end
         if (parLowLens[lowBase + i] != 2 * DIV) begin errors++; $display("[TB] FAIL b2b_par_low%0d: got %0d expected %0d", i, parLowLens[lowBase + i], 2 * DIV); end
      end
      for (int i = 1; i < 4; i++) begin
         checks++;
         if (loadCycles[loadBase + i] - loadCycles[loadBase + i - 1] != 16 * DIV) begin
            errors++;
            $display("[TB] FAIL b2b_spacing%0d: got %0d expected %0d", i, loadCycles[loadBase + i] - loadCycles[loadBase + i - 1], 16 * DIV);
         end
      end
      checks++;
      if (bytes_sent !== sentBase + 16'd4) begin errors++; $display("[TB] FAIL b2b_bytes_sent: got %0d expected %0d", bytes_sent, sentBase + 16'd4); end
   endtask

   task automatic test_backpressure();
      logic [7:0] data [6];
      int  accepted, rxBase;
      logic r;
      bit  ok;
      for (int i = 0; i < 6; i++) data[i] = 8'($urandom);
      rxBase   = rxBytes.size();
      accepted = 0;
      @(negedge clk);
      in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         in_data = data[accepted];
         r = in_ready;
         @(posedge clk);
         if (r) begin
            expQ.push_back(data[accepted]);
            accepted++;
         end
         @(negedge clk);
      end
`ifndef SERIALIZER_DRIVER_IDLE_CLK_EN
      checks++;
      if (accepted != 5) begin errors++; $display("[TB] FAIL bp_accepted: got %0d expected 5", accepted); end
`endif
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready: got %b expected 0", in_ready); end
      for (int t = 0; t < 4000 && accepted < 6; t++) begin
         in_data = data[accepted];
         r = in_ready;
         @(posedge clk);
         if (r) begin
            expQ.push_back(data[accepted]);
            accepted++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (accepted != 6) begin errors++; $display("[TB] FAIL bp_sixth: got %0d accepted expected 6", accepted); end
      waitDrain(rxBase + 6, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL bp_drain: got %0d bytes expected 6", rxBytes.size() - rxBase); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (rxBytes[rxBase + i] !== data[i]) begin errors++; $display("[TB] FAIL bp_byte%0d: got %h expected %h", i, rxBytes[rxBase + i], data[i]); end
      end
   endtask

   task automatic test_random();
      int  acceptCyc, rxBase, lowBase, gap, badLow;
      logic [15:0] sentBase;
      bit  ok;
      rxBase   = rxBytes.size();
      lowBase  = parLowLens.size();
      sentBase = bytes_sent;
      for (int i = 0; i < 12; i++) begin
         pushByte(8'($urandom), acceptCyc);
         gap = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(30 * DIV, 40 * DIV));
         @(negedge clk);
         in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      waitDrain(rxBase + 12, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL rand_drain: got %0d bytes expected 12", rxBytes.size() - rxBase); end
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (rxBytes[rxBase + i] !== expQ[rxBase + i]) begin
            errors++;
            $display("[TB] FAIL rand_byte%0d: got %h expected %h", i, rxBytes[rxBase + i], expQ[rxBase + i]);
         end
      end
      badLow = 0;
      for (int i = lowBase; i < parLowLens.size(); i++) if (parLowLens[i] != 2 * DIV) badLow++;
      checks += 2;
      if (badLow != 0) begin errors++; $display("[TB] FAIL rand_par_low: got %0d bad strobes expected 0", badLow); end
      if (bytes_sent !== sentBase + 16'd12) begin errors++; $display("[TB] FAIL rand_bytes_sent: got %0d expected %0d", bytes_sent, sentBase + 16'd12); end
   endtask

   task automatic test_reset_mid_byte();
      int  acceptCyc, rxBase, loadBase, target;
      rxBase   = rxBytes.size();
      loadBase = loadCycles.size();
      for (int i = 0; i < 3; i++) pushByte(8'($urandom), acceptCyc);
      @(negedge clk);
      in_valid = 1'b0;
      for (int t = 0; t < 1000 && loadCycles.size() <= loadBase; t++) @(negedge clk);
      target = loadCycles[loadBase] + 6 * DIV + 1;
      for (int t = 0; t < 1000 && cyc < target; t++) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks += 6;
      if (clk_ser !== 1'b0)     begin errors++; $display("[TB] FAIL mid_clk_ser: got %b expected 0", clk_ser); end
      if (clk_par !== 1'b1)     begin errors++; $display("[TB] FAIL mid_clk_par: got %b expected 1", clk_par); end
      if (data_par !== 8'h00)   begin errors++; $display("[TB] FAIL mid_data_par: got %h expected 00", data_par); end
      if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
      if (bytes_sent !== 16'd0) begin errors++; $display("[TB] FAIL mid_bytes_sent: got %0d expected 0", bytes_sent); end
      if (in_ready !== 1'b1)    begin errors++; $display("[TB] FAIL mid_in_ready: got %b expected 1", in_ready); end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (40 * DIV) @(negedge clk);
      checks += 3;
      if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL mid_after_busy: got %b expected 0", busy); end
      if (bytes_sent !== 16'd0) begin errors++; $display("[TB] FAIL mid_after_sent: got %0d expected 0", bytes_sent); end
      if (rxBytes.size() != rxBase) begin errors++; $display("[TB] FAIL mid_lost: got %0d bytes expected 0", rxBytes.size() - rxBase); end
      while (expQ.size() > rxBytes.size()) void'(expQ.pop_back());
   endtask

`ifdef SERIALIZER_DRIVER_IDLE_CLK_EN
   task automatic test_idle_clk();
      int  toggles, acceptCyc, rxBase, loadBase, lat;
      bit  parBad, ok;
      logic last;
      toggles = 0;
      parBad  = 1'b0;
      @(negedge clk);
      last = clk_ser;
      repeat (8 * DIV) begin
         @(negedge clk);
         if (clk_ser !== last) toggles++;
         if (clk_par !== 1'b1) parBad = 1'b1;
         last = clk_ser;
      end
      checks += 2;
      if (toggles < 7) begin errors++; $display("[TB] FAIL idle_toggles: got %0d expected >=7", toggles); end
      if (parBad) begin errors++; $display("[TB] FAIL idle_clk_par: got 0 expected 1"); end
      rxBase   = rxBytes.size();
      loadBase = loadCycles.size();
      repeat ($urandom_range(0, 2 * DIV - 1)) @(negedge clk);
      pushByte(8'($urandom), acceptCyc);
      @(negedge clk);
      in_valid = 1'b0;
      waitDrain(rxBase + 1, ok);
      lat = loadCycles[loadBase] - acceptCyc;
      checks += 3;
      if (!ok) begin errors++; $display("[TB] FAIL idle_drain: got %0d bytes expected 1", rxBytes.size() - rxBase); end
      if (rxBytes[rxBase] !== expQ[rxBase]) begin errors++; $display("[TB] FAIL idle_byte: got %h expected %h", rxBytes[rxBase], expQ[rxBase]); end
      if (lat < 1 || lat > 2 * DIV) begin errors++; $display("[TB] FAIL idle_latency: got %0d expected 1..%0d", lat, 2 * DIV); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_mid_byte();
`ifdef SERIALIZER_DRIVER_IDLE_CLK_EN
      test_idle_clk();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
